// File: rtl/avmm_pio_gen2.sv
// Second-generation Avalon-MM PIO slave: output register with atomic set/clear,
// synchronised input port, per-bit edge capture with maskable level interrupt.
module avmm_pio_gen2 #(
    parameter int                   OUT_WIDTH   = 9,
    parameter int                   IN_WIDTH    = 8,
    parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                   EDGE_TYPE   = 0,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [OUT_WIDTH-1:0] out_port,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    logic                 wr;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [IN_WIDTH-1:0]  wd_in;
    logic                 unused_wd;

    logic [OUT_WIDTH-1:0] data_out;
    logic [IN_WIDTH-1:0]  irq_mask;
    logic [IN_WIDTH-1:0]  edge_cap;

    logic [IN_WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [IN_WIDTH-1:0]  in_sync;
    logic [IN_WIDTH-1:0]  in_dly;
    logic [2:0]           warm_cnt;
    logic                 warm;

    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  fall;
    logic [IN_WIDTH-1:0]  edge_hit;
    logic [IN_WIDTH-1:0]  cap_clr;

    assign wr        = chipselect & ~write_n;
    assign wd_out    = writedata[OUT_WIDTH-1:0];
    assign wd_in     = writedata[IN_WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Output register: plain load plus atomic OR/AND-NOT so firmware needs no read-modify-write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA_OUT: data_out <= wd_out;
                ADDR_OUTSET:   data_out <= data_out | wd_out;
                ADDR_OUTCLEAR: data_out <= data_out & ~wd_out;
                default:       data_out <= data_out;
            endcase
        end
    end

    assign out_port = data_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr && (address == ADDR_IRQ_MASK)) begin
            irq_mask <= wd_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            in_dly <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            in_dly <= in_sync;
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    // Warm-up keeps levels already present at reset release from looking like edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
        end else if (warm_cnt != WARM_MAX) begin
            warm_cnt <= warm_cnt + 3'd1;
        end
    end

    assign warm = (warm_cnt == WARM_MAX);

    always_comb begin
        rise = in_sync & ~in_dly;
        fall = ~in_sync & in_dly;
        case (EDGE_TYPE)
            1:       edge_hit = fall;
            2:       edge_hit = rise | fall;
            default: edge_hit = rise;
        endcase
    end

    assign cap_clr = (wr && (address == ADDR_EDGE_CAP)) ? wd_in : '0;

    // New edges are OR-ed in after the clear so a coincident edge survives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | (warm ? edge_hit : '0);
        end
    end

    assign irq = |(edge_cap & irq_mask);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA_OUT: readdata[OUT_WIDTH-1:0] = data_out;
            ADDR_DATA_IN:  readdata[IN_WIDTH-1:0]  = in_sync;
            ADDR_IRQ_MASK: readdata[IN_WIDTH-1:0]  = irq_mask;
            ADDR_EDGE_CAP: readdata[IN_WIDTH-1:0]  = edge_cap;
            default:       readdata = '0;
        endcase
    end

endmodule
